// File: rtl/conv_encoder.sv
// Rate-1/2, K=7 convolutional encoder (g0=133, g1=171) with 802.11a puncturing to 2/3 and 3/4.
// Info bits in, one coded bit per cycle out; the zero tail is appended automatically after in_last.
module conv_encoder #(
   parameter logic [6:0] G0        = 7'o133,
   parameter logic [6:0] G1        = 7'o171,
   parameter int         TAIL_BITS = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] rate,
   input  logic       in_bit,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic       out_bit,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       busy
);

   localparam int CW = $clog2(TAIL_BITS + 1);

   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

   state_t        state_q;
   logic [5:0]    sr_q;
   logic [1:0]    p_q;
   logic [1:0]    rate_q;
   logic [CW-1:0] tailCnt_q;
   logic          busy_q;
   logic          headBit_q;
   logic          headValid_q;
   logic          headLast_q;
   logic          nextBit_q;
   logic          nextValid_q;
   logic          nextLast_q;

   logic          pop;
   logic          canStep;
   logic          stepData;
   logic          stepTail;
   logic          doStep;
   logic          stepBit;
   logic          finalStep;
   logic          codeA;
   logic          codeB;
   logic          keepA;
   logic          keepB;
   logic [1:0]    p_d;

   // A step is admitted only when the two-entry buffer will be empty after this cycle's pop,
   // which keeps the output busy every cycle without ever overflowing the buffer.
   always_comb begin
      pop       = headValid_q & out_ready;
      canStep   = !headValid_q | (!nextValid_q & pop);
      stepData  = (state_q == DATA) & in_valid & canStep;
      stepTail  = (state_q == TAIL) & canStep & (tailCnt_q != '0);
      doStep    = stepData | stepTail;
      stepBit   = stepData & in_bit;
      finalStep = stepTail & (tailCnt_q == CW'(1));

      codeA = G0[6] & stepBit;
      codeB = G1[6] & stepBit;
      for (int d = 1; d <= 6; d++) begin
         codeA = codeA ^ (G0[6-d] & sr_q[d-1]);
         codeB = codeB ^ (G1[6-d] & sr_q[d-1]);
      end

      keepA = 1'b1;
      keepB = 1'b1;
      p_d   = 2'd0;
      case (rate_q)
         2'b01: begin
            keepB = (p_q == 2'd0);
            p_d   = (p_q == 2'd1) ? 2'd0 : p_q + 2'd1;
         end
         2'b10: begin
            keepA = (p_q != 2'd2);
            keepB = (p_q != 2'd1);
            p_d   = (p_q == 2'd2) ? 2'd0 : p_q + 2'd1;
         end
         default: begin
            keepA = 1'b1;
            keepB = 1'b1;
         end
      endcase
   end

   assign in_ready  = (state_q == DATA) & canStep;
   assign out_bit   = headBit_q;
   assign out_valid = headValid_q;
   assign out_last  = headValid_q & headLast_q;
   assign busy      = busy_q;

   // Frame control, encoder state and the output buffer share one register block; a step
   // always lands in an empty buffer, so its load simply overrides the pop shift.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         p_q         <= '0;
         rate_q      <= '0;
         tailCnt_q   <= '0;
         busy_q      <= 1'b0;
         headBit_q   <= 1'b0;
         headValid_q <= 1'b0;
         headLast_q  <= 1'b0;
         nextBit_q   <= 1'b0;
         nextValid_q <= 1'b0;
         nextLast_q  <= 1'b0;
      end else begin
         if (pop) begin
            headBit_q   <= nextBit_q;
            headValid_q <= nextValid_q;
            headLast_q  <= nextLast_q;
            nextBit_q   <= 1'b0;
            nextValid_q <= 1'b0;
            nextLast_q  <= 1'b0;
         end

         if (doStep) begin
            sr_q        <= {sr_q[4:0], stepBit};
            p_q         <= p_d;
            headValid_q <= 1'b1;
            if (keepA) begin
               headBit_q   <= codeA;
               headLast_q  <= finalStep & !keepB;
               nextBit_q   <= codeB & keepB;
               nextValid_q <= keepB;
               nextLast_q  <= finalStep & keepB;
            end else begin
               headBit_q   <= codeB;
               headLast_q  <= finalStep;
            end
         end

         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= DATA;
                  sr_q    <= '0;
                  p_q     <= '0;
                  rate_q  <= rate;
                  busy_q  <= 1'b1;
               end
            end
            DATA: begin
               if (stepData && in_last) begin
                  state_q   <= TAIL;
                  tailCnt_q <= CW'(TAIL_BITS);
               end
            end
            TAIL: begin
               if (stepTail) begin
                  tailCnt_q <= tailCnt_q - CW'(1);
               end
               if (pop && headLast_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_encoder.sv
// Randomised self-checking bench for conv_encoder against a window/parity reference encoder
// with table-driven puncturing, plus fixed impulse vectors and control-edge scenarios.
module tb_conv_encoder;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] rate;
   logic       in_bit;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic       out_bit;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       busy;

   int errors = 0;
   int checks = 0;

   bit infoBits[$];
   bit expBits[$];

   int firstAcc;
   int lastAcc;

   conv_encoder dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .rate      (rate),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_bit   (out_bit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference: the 7-bit window holds the current bit in bit 6 and older bits below it,
   // so each output is just the parity of generator AND window.
   function automatic void buildExpected(input logic [1:0] r);
      int period;
      int past;
      int window;
      int p;
      bit a;
      bit b;
      expBits.delete();
      period = (r == 2'd1) ? 2 : (r == 2'd2) ? 3 : 1;
      past   = 0;
      p      = 0;
      for (int k = 0; k < infoBits.size() + 6; k++) begin
         window = ((k < infoBits.size() && infoBits[k]) ? 64 : 0) | past;
         a = bit'($countones(window & 'o133) % 2);
         b = bit'($countones(window & 'o171) % 2);
         if (p != 2) expBits.push_back(a);
         if (p != 1) expBits.push_back(b);
         past = window >> 1;
         p    = (p + 1) % period;
      end
   endfunction

   function automatic void makeRandomBits(input int n);
      infoBits.delete();
      for (int i = 0; i < n; i++) infoBits.push_back(bit'($urandom_range(0, 1)));
   endfunction

   task automatic applyStimulus(input logic [1:0] rateSel, input int stallAt, input int stallLen,
                                input bit randReady, input bit pokeStart, input int abortAfter,
                                output int firstA, output int lastA);
      int  n;
      int  inIdx;
      int  outIdx;
      int  cyc;
      int  tailCyc;
      bit  done;
      bit  aborted;
      bit  held;
      bit  heldBit;
      n       = infoBits.size();
      inIdx   = 0;
      outIdx  = 0;
      cyc     = 0;
      tailCyc = 0;
      done    = 1'b0;
      aborted = 1'b0;
      held    = 1'b0;
      heldBit = 1'b0;
      firstA  = -1;
      lastA   = -1;
      @(negedge clock);
      start = 1'b1;
      rate  = rateSel;
      @(negedge clock);
      start = 1'b0;
      rate  = 2'($urandom_range(0, 3));
      while (!done && !aborted && cyc < 5000) begin
         in_valid  = (inIdx < n);
         in_bit    = (inIdx < n) ? infoBits[inIdx] : 1'b0;
         in_last   = (inIdx == n - 1);
         out_ready = (cyc >= stallAt && cyc < stallAt + stallLen) ? 1'b0 :
                     (randReady ? ($urandom_range(0, 3) != 0) : 1'b1);
         start     = pokeStart && (cyc == 3);
         #1;
         if (cyc == 0) checkOutput("busy_after_start", busy, 1);
         if (held) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_bit", out_bit, heldBit);
         end
         held    = out_valid && !out_ready;
         heldBit = out_bit;
         if (out_valid && !out_ready) checkOutput("hold_in_ready", in_ready, 0);
         if (in_valid && in_ready) begin
            if (firstA < 0) firstA = cyc;
            lastA = cyc;
            inIdx++;
         end
         if (out_valid && out_ready) begin
            if (outIdx >= expBits.size()) begin
               checkOutput("bit_count_overrun", outIdx + 1, expBits.size());
               done = 1'b1;
            end else begin
               checkOutput($sformatf("bit%0d", outIdx), out_bit, expBits[outIdx]);
               checkOutput($sformatf("last%0d", outIdx), out_last, (outIdx == expBits.size() - 1));
               if (out_last) done = 1'b1;
               outIdx++;
            end
         end
         if (abortAfter >= 0 && inIdx == n) begin
            if (tailCyc == abortAfter) aborted = 1'b1;
            tailCyc++;
         end
         @(negedge clock);
         cyc++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_bit   = 1'b0;
      start    = 1'b0;
      if (!aborted) begin
         #1;
         checkOutput("frame_done", done, 1);
         checkOutput("bit_count", outIdx, expBits.size());
         checkOutput("busy_end", busy, 0);
         checkOutput("valid_end", out_valid, 0);
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      rate      = 2'd0;
      in_bit    = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      checkOutput("reset_in_ready", in_ready, 0);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_out_bit", out_bit, 0);
      checkOutput("reset_out_last", out_last, 0);
      checkOutput("reset_busy", busy, 0);
      reset = 1'b0;

      infoBits = '{1'b1};
      expBits  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      applyStimulus(2'd0, -1, 0, 1'b0, 1'b0, -1, firstAcc, lastAcc);

      expBits  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      applyStimulus(2'd2, -1, 0, 1'b0, 1'b0, -1, firstAcc, lastAcc);

      makeRandomBits(30);
      buildExpected(2'd0);
      applyStimulus(2'd0, 10, 5, 1'b0, 1'b0, -1, firstAcc, lastAcc);

      // At rate 2/3 bits are accepted at offsets 0,2,3,5,6,... so bit 47 lands 71 cycles after bit 0.
      makeRandomBits(48);
      buildExpected(2'd1);
      applyStimulus(2'd1, -1, 0, 1'b0, 1'b0, -1, firstAcc, lastAcc);
      checkOutput("rate23_accept_span", lastAcc - firstAcc, 71);

      makeRandomBits(40);
      buildExpected(2'd3);
      applyStimulus(2'd3, -1, 0, 1'b1, 1'b1, -1, firstAcc, lastAcc);

      for (int r = 0; r < 3; r++) begin
         makeRandomBits(int'($urandom_range(20, 60)));
         buildExpected(2'(r));
         applyStimulus(2'(r), 7, 4, 1'b1, 1'b0, -1, firstAcc, lastAcc);
      end

      makeRandomBits(20);
      buildExpected(2'd2);
      applyStimulus(2'd2, -1, 0, 1'b0, 1'b0, 2, firstAcc, lastAcc);
      reset     = 1'b1;
      out_ready = 1'b0;
      @(negedge clock);
      #1;
      checkOutput("abort_in_ready", in_ready, 0);
      checkOutput("abort_out_valid", out_valid, 0);
      checkOutput("abort_out_bit", out_bit, 0);
      checkOutput("abort_out_last", out_last, 0);
      checkOutput("abort_busy", busy, 0);
      reset     = 1'b0;
      out_ready = 1'b1;

      makeRandomBits(25);
      buildExpected(2'd1);
      applyStimulus(2'd1, -1, 0, 1'b1, 1'b0, -1, firstAcc, lastAcc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
